// File: rtl/instr_mem_loader.sv
// Instruction memory loader: receives a length-prefixed program image over a
// byte-serial link and writes it word by word into instruction memory while
// holding the CPU in reset.
module instr_mem_loader #(
  parameter int unsigned RAM_SIZE     = 256,
  parameter int unsigned RAM_SIZE_BIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [RAM_SIZE_BIT:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_len;
  logic [31:0]           r_asm;
  logic [1:0]            r_idx;
  logic [RAM_SIZE_BIT:0] r_wc;
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;

  logic                  w_can_start;
  logic                  w_start;
  logic [15:0]           w_len;
  logic                  w_len_bad;
  logic                  w_last_wr;
  logic                  w_accept;
  logic [31:0]           w_word;

  // Decode of start/length/byte acceptance conditions
  always_comb begin
    w_can_start = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR);
    w_start     = w_can_start && start;
    w_len       = {r_len[15:8], byte_data};
    w_len_bad   = (w_len == 16'd0) || ({16'd0, w_len} > RAM_SIZE);
    // The write cycle of word N ends the load; a byte arriving then is not part of the frame.
    w_last_wr   = r_we && (32'(r_wc) == 32'(r_len));
    w_accept    = (r_state == S_DATA) && byte_valid && !w_last_wr;
    w_word      = {r_asm[23:0], byte_data};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_LEN_HI;
      S_LEN_HI:                if (byte_valid) w_next = S_LEN_LO;
      S_LEN_LO:                if (byte_valid) w_next = w_len_bad ? S_ERROR : S_DATA;
      S_DATA:                  if (w_last_wr) w_next = S_DONE;
      default:                 w_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state
  always_comb begin
    cpu_hold = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (r_state)
      S_LEN_HI, S_LEN_LO, S_DATA: cpu_hold = 1'b1;
      S_DONE:                     done     = 1'b1;
      S_ERROR:                    error    = 1'b1;
      default:                    ;
    endcase
  end

  // Length capture, word assembly and memory write generation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len   <= '0;
      r_asm   <= '0;
      r_idx   <= '0;
      r_wc    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_start) begin
        r_wc  <= '0;
        r_idx <= '0;
      end
      if ((r_state == S_LEN_HI) && byte_valid) r_len[15:8] <= byte_data;
      if ((r_state == S_LEN_LO) && byte_valid) r_len[7:0]  <= byte_data;
      if (w_accept) begin
        r_asm <= w_word;
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_we    <= 1'b1;
          r_wdata <= w_word;
          r_addr  <= 32'(r_wc) << 2;
          r_wc    <= r_wc + 1'b1;
        end
      end
    end
  end

  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign word_count = r_wc;

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter RAM_SIZE, default 256, instruction memory depth in 32-bit words.
REQ-002 Parameter RAM_SIZE_BIT, default 8, log2(RAM_SIZE).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse requesting a new program load.
REQ-006 byte_valid  input  1  one-cycle strobe: byte_data carries a valid byte.
REQ-007 byte_data  input  8  serial-link byte, big-endian within each field.
REQ-008 mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
REQ-009 mem_addr  output  32  byte address of word being written; bits [1:0] always 0.
REQ-010 mem_wdata  output  32  instruction word being written.
REQ-011 cpu_hold  output  1  high while a load is in progress; holds the CPU in reset.
REQ-012 done  output  1  high after a successful load, until next start or reset.
REQ-013 error  output  1  high after a rejected length, until next start or reset.
REQ-014 word_count  output  RAM_SIZE_BIT+1  words written in current/last load.

Function
REQ-015 Frame format: 2-byte word count N (high byte first), then 4*N instruction bytes, each word MSB byte first.
REQ-016 States: IDLE, LEN_HI, LEN_LO, DATA, DONE, ERROR.
REQ-017 IDLE/DONE/ERROR: start=1 -> LEN_HI; clears done, error, word_count, byte index; cpu_hold=1 from next cycle.
REQ-018 start SHALL be ignored in LEN_HI, LEN_LO and DATA.
REQ-019 byte_valid SHALL be ignored in IDLE, DONE and ERROR.
REQ-020 LEN_HI: byte_valid -> latch N[15:8], go LEN_LO.
REQ-021 LEN_LO: byte_valid -> latch N[7:0]; N==0 or N>RAM_SIZE -> ERROR; else DATA.
REQ-022 DATA: each byte shifts into a 32-bit assembly register (new byte to [7:0]); 2-bit byte index increments, wrapping 3->0.
REQ-023 On the fourth byte of a word: next cycle mem_we=1, mem_wdata=assembled word, mem_addr={word_count,2'b00} zero-extended; word_count increments in that same cycle.
REQ-024 mem_addr and mem_wdata SHALL hold their last values when mem_we=0.
REQ-025 A byte_valid arriving in the same cycle as mem_we SHALL be accepted into the next word without loss.
REQ-026 When word_count reaches N (on the write cycle of word N) -> DONE next cycle; done=1, cpu_hold=0.
REQ-027 ERROR: error=1, cpu_hold=0, no memory writes.
REQ-028 No backpressure: the block SHALL accept one byte per cycle at full rate.
REQ-029 Address SHALL never exceed (RAM_SIZE-1)*4; guaranteed by REQ-021.
REQ-030 Latency: last byte of frame to done=1 is 2 cycles (write cycle, then DONE).

Reset
REQ-031 reset=1 -> state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0, word_count=0, byte index 0.
REQ-032 reset SHALL take priority over start and byte_valid in the same cycle.
REQ-033 reset mid-load SHALL abort immediately; partially written words remain in memory; no further writes.

Verification
REQ-034 Bytes 00 01 20 04 00 03 -> one write, mem_addr=0x0, mem_wdata=0x20040003; done=1 two cycles after last byte; word_count=1.
REQ-035 N=3 at one byte per cycle, words 0x20040003, 0x0C000003, 0x1000FFFF -> writes at addresses 0x0, 0x4, 0x8 in order; no byte dropped; cpu_hold high from start+1 until DONE.
REQ-036 Length bytes 00 00, and separately 01 01 (N=257) -> error=1, mem_we never asserted, cpu_hold=0.
REQ-037 N=256 full image -> last write at mem_addr=0x3FC, word_count=256, done=1.
REQ-038 reset asserted after 2 of 4 words written -> all outputs return to reset values next cycle; subsequent byte_valid pulses cause no write until new start.
REQ-039 start pulse during DATA and byte_valid during IDLE -> both ignored; load completes with correct data.
